// File: rtl/icache_refill_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_refill_pkg: shared widths, FSM states, word-select helper  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package icache_refill_pkg;

  localparam int WORD             = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int CACHE_WORD_NUM   = CACHE_LINE_WIDTH / WORD;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_REQ    = 2'd1,
    ICACHE_REPLAY = 2'd2
  } icache_state_e;

  function automatic logic [WORD-1:0] select_word(
    input logic [CACHE_LINE_WIDTH-1:0] line,
    input logic [1:0]                  sel
  );
    return line[{sel, 5'd0} +: WORD];
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_line_ram: valid/tag/data store, async read, sync write    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_line_ram
  import icache_refill_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = CACHE_LINE_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];

  // Only the valid bits need reset; stale tag/data are masked by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[wr_index]  <= wr_tag;
      r_data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_data  = r_data[rd_index];

endmodule
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_refill: direct-mapped I-cache with single-line refill     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int INDEX_W  = 6,
  parameter int LINE_W   = CACHE_LINE_WIDTH,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  input  logic              flush,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic              icache_stall,
  output logic              memory_valid_for_ICache,
  output logic [31:0]       load_inst_addr,
  input  logic              memory_ready_for_ICache,
  input  logic [LINE_W-1:0] inst_from_mem
);

  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

  icache_state_e r_state, w_state_nxt;
  logic          r_inst_valid, w_inst_valid_nxt;
  logic [31:0]   r_inst, w_inst_nxt;
  logic          r_mem_valid, w_mem_valid_nxt;
  logic [31:0]   r_load_addr, w_load_addr_nxt;
  logic [1:0]    r_miss_word, w_miss_word_nxt;
  logic          w_wr_en;
  logic          w_stall;

  logic               w_rd_valid;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [LINE_W-1:0]  w_rd_data;
  logic               w_hit;
  logic               w_unused;

  assign w_unused = ^fetch_pc[1:0];

  icache_line_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_line_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (fetch_pc[OFFSET_W +: INDEX_W]),
    .rd_valid (w_rd_valid),
    .rd_tag   (w_rd_tag),
    .rd_data  (w_rd_data),
    .wr_en    (w_wr_en),
    .wr_index (r_load_addr[OFFSET_W +: INDEX_W]),
    .wr_tag   (r_load_addr[31:OFFSET_W+INDEX_W]),
    .wr_data  (inst_from_mem)
  );

  assign w_hit = w_rd_valid && (w_rd_tag == fetch_pc[31:OFFSET_W+INDEX_W]);

  always_comb begin
    w_state_nxt      = r_state;
    w_inst_valid_nxt = 1'b0;
    w_inst_nxt       = r_inst;
    w_mem_valid_nxt  = r_mem_valid;
    w_load_addr_nxt  = r_load_addr;
    w_miss_word_nxt  = r_miss_word;
    w_wr_en          = 1'b0;
    w_stall          = 1'b0;
    case (r_state)
      ICACHE_IDLE: begin
        if (fetch_valid && !flush) begin
          if (w_hit) begin
            w_inst_valid_nxt = 1'b1;
            w_inst_nxt       = select_word(w_rd_data, fetch_pc[3:2]);
          end else begin
            w_stall         = 1'b1;
            w_state_nxt     = ICACHE_REQ;
            w_mem_valid_nxt = 1'b1;
            w_load_addr_nxt = {fetch_pc[31:OFFSET_W], {OFFSET_W{1'b0}}};
            w_miss_word_nxt = fetch_pc[3:2];
          end
        end
      end
      ICACHE_REQ: begin
        w_stall = 1'b1;
        // A ready pulse always delivers good data, so the line is kept even if flushed.
        if (memory_ready_for_ICache) begin
          w_wr_en         = 1'b1;
          w_mem_valid_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = ICACHE_IDLE;
          end else begin
            w_state_nxt      = ICACHE_REPLAY;
            w_inst_valid_nxt = 1'b1;
            w_inst_nxt       = select_word(inst_from_mem, r_miss_word);
          end
        end else if (flush) begin
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = ICACHE_IDLE;
        end
      end
      ICACHE_REPLAY: begin
        w_state_nxt = ICACHE_IDLE;
      end
      default: begin
        w_state_nxt = ICACHE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ICACHE_IDLE;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_mem_valid  <= 1'b0;
      r_load_addr  <= '0;
      r_miss_word  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_load_addr  <= w_load_addr_nxt;
      r_miss_word  <= w_miss_word_nxt;
    end
  end

  // A flush landing on the replay cycle kills the replayed word.
  assign inst_valid              = r_inst_valid && !((r_state == ICACHE_REPLAY) && flush);
  assign inst                    = r_inst;
  assign icache_stall            = w_stall;
  assign memory_valid_for_ICache = r_mem_valid;
  assign load_inst_addr          = r_load_addr;

endmodule
`default_nettype wire
